// File: rtl/pc_fetch_ctrl_if.sv
// Fetch controller bundle: decode-side control, redirect inputs and the
// instruction-memory request/response channel.
interface pc_fetch_ctrl_if;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        trap_i;
  logic        imem_ready_i;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        instr_valid_o;

  // Fetch controller side
  modport master (
    input  stall_i, branch_i, branch_target_i, trap_i,
           imem_ready_i, imem_valid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, pc_o, instr_o, instr_valid_o
  );

  // Environment side: decode, redirect sources and instruction memory
  modport slave (
    output stall_i, branch_i, branch_target_i, trap_i,
           imem_ready_i, imem_valid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, pc_o, instr_o, instr_valid_o
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, issues one instruction-memory
// request at a time, holds the fetched word while decode stalls and discards
// responses made stale by a trap or branch redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        drop_reg, drop_next;
  logic        valid_reg, valid_next;

  logic        redirect;
  logic [31:0] target;

  // Trap wins over branch; fetch addresses are always word aligned.
  assign redirect = bus.trap_i | bus.branch_i;
  assign target   = bus.trap_i ? {TRAP_VEC[31:2], 2'b00}
                               : {bus.branch_target_i[31:2], 2'b00};

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'h0;
      drop_reg     <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      drop_reg     <= drop_next;
      valid_reg    <= valid_next;
    end
  end

  // Next-state and datapath update for the fetch sequencer.
  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    drop_next     = drop_reg;
    valid_next    = valid_reg;

    unique case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        state_next = REQ;
        if (redirect) fetch_pc_next = target;
      end

      REQ: begin
        // Any instruction shown during REQ was consumed on the way in.
        valid_next = 1'b0;
        if (bus.imem_ready_i) begin
          state_next = WAIT;
          if (redirect) begin
            // The old address was accepted, so its response must be thrown away.
            fetch_pc_next = target;
            drop_next     = 1'b1;
          end
        end else if (redirect) begin
          fetch_pc_next = target;
        end
      end

      WAIT: begin
        valid_next = 1'b0;
        if (bus.imem_valid_i) begin
          drop_next  = 1'b0;
          state_next = REQ;
          if (redirect) begin
            fetch_pc_next = target;
          end else if (!drop_reg) begin
            instr_next    = bus.imem_rdata_i;
            pc_next       = fetch_pc_reg;
            valid_next    = 1'b1;
            fetch_pc_next = fetch_pc_reg + 32'd4;
            state_next    = bus.stall_i ? HOLD : REQ;
          end
        end else if (redirect) begin
          fetch_pc_next = target;
          drop_next     = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_next    = 1'b0;
          fetch_pc_next = target;
          state_next    = REQ;
        end else if (!bus.stall_i) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.imem_req_o    = (state_reg == REQ);
  assign bus.imem_addr_o   = fetch_pc_reg;
  assign bus.pc_o          = pc_reg;
  assign bus.instr_o       = instr_reg;
  assign bus.instr_valid_o = valid_reg;

endmodule
